// File: rtl/keccak_feed_pkg.sv
// Shared types and widths for the keccak byte-stream feeder.
package keccak_feed_pkg;

    localparam int WORD_W     = 32;
    localparam int BYTE_W     = 8;
    localparam int BYTE_NUM_W = 2;
    localparam int LANES      = 4;
    localparam int CNT_W      = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CRST,
        ST_FILL,
        ST_SEND,
        ST_SEND_PAD,
        ST_WAIT_OUT,
        ST_DONE
    } feed_state_e;

endpackage

// File: rtl/keccak_byte_packer.sv
// Packs bytes big-endian into a 32-bit word; lane 0 lands in [31:24].
module keccak_byte_packer
    import keccak_feed_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [BYTE_W-1:0] data_i,
    output logic [WORD_W-1:0] word_o,
    output logic [CNT_W-1:0]  cnt_o
);

    logic [WORD_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // cnt saturates at LANES so a stray load can never wrap into lane 0
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (clear_i) begin
            word_d = '0;
            cnt_d  = '0;
        end else if (load_i && (cnt_q < CNT_W'(LANES))) begin
            for (int i = 0; i < LANES; i++) begin
                if (cnt_q == CNT_W'(i)) begin
                    word_d[WORD_W-1-i*BYTE_W -: BYTE_W] = data_i;
                end
            end
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

    assign word_o = word_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/keccak_msg_feeder.sv
// Byte-stream front end for the keccak core: resets the core per message,
// feeds big-endian words with end-of-message padding, and flags digest ready.
module keccak_msg_feeder
    import keccak_feed_pkg::*;
#(
    parameter int RST_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BYTE_W-1:0]     s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  k_reset,
    output logic [WORD_W-1:0]     k_in,
    output logic                  k_in_ready,
    output logic                  k_is_last,
    output logic [BYTE_NUM_W-1:0] k_byte_num,
    input  logic                  k_buffer_full,
    input  logic                  k_out_ready,
    output logic                  busy,
    output logic                  msg_done
);

    localparam logic [3:0] RST_LAST = 4'(RST_CYCLES - 1);

    feed_state_e       state_q, state_d;
    logic [3:0]        rcnt_q, rcnt_d;
    logic              last_q, last_d;
    logic              full_q, full_d;
    logic              k_reset_q, k_reset_d;
    logic              pk_clear, pk_load;
    logic [WORD_W-1:0] pk_word;
    logic [CNT_W-1:0]  pk_cnt;

    keccak_byte_packer u_packer (
        .clk_i   (clk),
        .rst_ni  (reset),
        .clear_i (pk_clear),
        .load_i  (pk_load),
        .data_i  (s_data),
        .word_o  (pk_word),
        .cnt_o   (pk_cnt)
    );

    always_comb begin
        state_d  = state_q;
        rcnt_d   = rcnt_q;
        last_d   = last_q;
        full_d   = full_q;
        pk_clear = 1'b0;
        pk_load  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pk_clear = 1'b1;
                if (s_valid) begin
                    state_d = ST_CRST;
                    rcnt_d  = '0;
                end
            end
            ST_CRST: begin
                if (rcnt_q == RST_LAST) begin
                    state_d = ST_FILL;
                end else begin
                    rcnt_d = rcnt_q + 4'd1;
                end
            end
            ST_FILL: begin
                if (s_valid) begin
                    pk_load = 1'b1;
                    if (s_last || (pk_cnt == CNT_W'(LANES - 1))) begin
                        state_d = ST_SEND;
                        last_d  = s_last;
                        full_d  = (pk_cnt == CNT_W'(LANES - 1));
                    end
                end
            end
            ST_SEND: begin
                if (!k_buffer_full) begin
                    if (!last_q) begin
                        state_d  = ST_FILL;
                        pk_clear = 1'b1;
                    end else if (full_q) begin
                        // a message ending on a word boundary still needs an is_last word
                        state_d = ST_SEND_PAD;
                    end else begin
                        state_d = ST_WAIT_OUT;
                    end
                end
            end
            ST_SEND_PAD: begin
                if (!k_buffer_full) begin
                    state_d = ST_WAIT_OUT;
                end
            end
            ST_WAIT_OUT: begin
                if (k_out_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign k_reset_d = (state_d == ST_CRST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            rcnt_q    <= '0;
            last_q    <= 1'b0;
            full_q    <= 1'b0;
            k_reset_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            rcnt_q    <= rcnt_d;
            last_q    <= last_d;
            full_q    <= full_d;
            k_reset_q <= k_reset_d;
        end
    end

    assign s_ready    = (state_q == ST_FILL);
    assign k_reset    = k_reset_q;
    assign k_in_ready = (state_q == ST_SEND) || (state_q == ST_SEND_PAD);
    assign k_in       = (state_q == ST_SEND) ? pk_word : '0;
    assign k_is_last  = ((state_q == ST_SEND) && last_q && !full_q) || (state_q == ST_SEND_PAD);
    assign k_byte_num = ((state_q == ST_SEND) && last_q && !full_q) ? pk_cnt[BYTE_NUM_W-1:0] : '0;
    assign busy       = (state_q != ST_IDLE);
    assign msg_done   = (state_q == ST_DONE);

endmodule

// File: doc/keccak_msg_feeder.md
Name: keccak_msg_feeder

Overview:
Byte-stream front end for the keccak core. It takes a message as a stream of bytes with a valid/ready handshake and a last flag. It then drives the core's word interface: a start-of-message core reset pulse, big-endian 32-bit words with in_ready, is_last and byte_num, and stalls while buffer_full is high. It waits for out_ready, then pulses msg_done so the system can sample the 512-bit digest directly from the core's out bus.

Parameters:
RST_CYCLES, 1, number of cycles k_reset is held high before each message (1..15)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low; 0 = block in reset
s_data  input  8  message byte
s_valid  input  1  s_data valid
s_last  input  1  s_data is the final byte of the message
s_ready  output  1  byte accepted when s_valid && s_ready at rising clk
k_reset  output  1  to core reset; active-high, synchronous to clk
k_in  output  32  to core in; first byte of word in [31:24]
k_in_ready  output  1  to core in_ready
k_is_last  output  1  to core is_last
k_byte_num  output  2  to core byte_num; valid bytes in final word, 0..3
k_buffer_full  input  1  from core buffer_full
k_out_ready  input  1  from core out_ready
busy  output  1  high in every state except IDLE
msg_done  output  1  one-cycle pulse when the digest is valid

Behaviour:
- Reset values while reset=0: state IDLE, k_reset=1 (holds the core in reset), s_ready=0, k_in=0, k_in_ready=0, k_is_last=0, k_byte_num=0, busy=0, msg_done=0.
- On the first clk after reset deasserts, k_reset goes to 0.
- States: IDLE, CRST, FILL, SEND, SEND_PAD, WAIT_OUT, DONE.
- IDLE:
  - s_ready=0.
  - s_valid=1 -> CRST. The byte is not consumed.
- CRST:
  - k_reset=1 for exactly RST_CYCLES cycles (counter).
  - Then -> FILL; k_reset=0.
- FILL:
  - s_ready=1.
  - Each accepted byte is written into lane cnt: lane 0 = [31:24], lane 3 = [7:0]. cnt increments.
  - Unfilled lanes are 0.
  - On acceptance of the 4th byte, or of a byte with s_last=1 -> SEND next cycle. The pending flags are latched: last, and full = (cnt==4).
- SEND:
  - s_ready=0, k_in_ready=1, k_in = packed word.
  - k_is_last = last && !full.
  - k_byte_num = cnt mod 4 when k_is_last, else 0.
  - The word is accepted at the clk edge where k_in_ready && !k_buffer_full. While k_buffer_full=1, all k_* outputs are held unchanged.
  - On accept:
    - if !last -> FILL with cnt=0 and word cleared;
    - if last && full -> SEND_PAD;
    - if last && !full -> WAIT_OUT.
- SEND_PAD:
  - k_in=0, k_in_ready=1, k_is_last=1, k_byte_num=0.
  - Same accept rule as SEND; on accept -> WAIT_OUT.
- WAIT_OUT:
  - k_in_ready=0, k_is_last=0.
  - k_out_ready=1 -> DONE.
- DONE:
  - msg_done=1 for one cycle -> IDLE.
- Throughput: at most one word per 5 cycles (4 FILL cycles + 1 SEND cycle). FILL and SEND do not overlap.
- k_in_ready is never high outside SEND and SEND_PAD. k_is_last is high for exactly one accepted word per message.
- Zero-length messages are not supported: every message carries at least one byte.
- k_buffer_full rising during FILL has no effect until SEND.
- k_out_ready is ignored outside WAIT_OUT.
- Asynchronous reset in any state aborts the message: all reset values are applied immediately and partial bytes are discarded. The next message restarts with CRST.
- cnt is 3 bits, range 0..4. It never wraps.

Decomposition:
- Package keccak_feed_pkg:
  - state enum;
  - WORD_W=32, BYTE_W=8, BYTE_NUM_W=2;
  - LANES=4.
- Sub-module keccak_byte_packer:
  - load/clear interface;
  - outputs word[31:0] and cnt[2:0];
  - performs lane placement.
- FSM, reset counter and core-side output registers stay in the top module.

Test Plan:
- Send "abc" (0x61,0x62,0x63, last on 0x63).
  - Expect k_reset high 1 cycle.
  - Then one word k_in=0x61626300 with k_is_last=1, k_byte_num=3.
  - msg_done pulses 1 cycle after k_out_ready.
- Send "Hell" (last on 'l').
  - Expect word 0x48656C6C with is_last=0.
  - Then pad word 0x00000000 with is_last=1, byte_num=0.
- Send "The quick brown fox jumps over the lazy dog" (43 bytes).
  - Expect 10 full words then 0x646F6700 with is_last=1, byte_num=3.
  - The first word is 0x54686520.
- Hold k_buffer_full=1 for 7 cycles during SEND of word 0x31323334.
  - k_in, k_in_ready and k_is_last stay constant.
  - Exactly one accept occurs after release.
  - The next word is 0x35360000 with byte_num=2.
- Assert reset=0 mid-message after 6 bytes.
  - Outputs take reset values immediately, with k_reset=1.
  - A following "ab" message yields 0x61620000 with byte_num=2 and no stale bytes.
- RST_CYCLES=3 with s_valid toggling randomly.
  - k_reset is high exactly 3 cycles per message.
  - s_ready is never high outside FILL.
